tlb_assoc_asid: RTL and testbench

- Fully-associative, parametrised TLB with ASID tagging, global pages and selectable replacement policy (FIFO / LRU / Clock).
- Sits between the CPU address path and the page-table walker inside the virtual memory controller.
- Adds three things the single-space controller lacks: per-process ASIDs, targeted flushes, and permission checking at lookup time.

---
 rtl/tlb_pkg.sv | 32 +++
 rtl/tlb_victim_select.sv | 53 +++++
 rtl/tlb_assoc_asid.sv | 135 +++++++++++++
 tb/tb_tlb_assoc_asid.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// tlb_pkg: shared PTE layout, flush/policy encodings and TLB entry type
package tlb_pkg;
  localparam int PTE_V = 0;
  localparam int PTE_R = 1;
  localparam int PTE_W = 2;
  localparam int PTE_X = 3;
  localparam int PTE_U = 4;
  localparam int PTE_G = 5;
  localparam int PPN_LSB = 12;
  localparam int VPN_MAX = 32;
  localparam int PPN_MAX = 32;
  localparam int ASID_MAX = 16;
  localparam logic [1:0] FLUSH_ALL = 2'b00;
  localparam logic [1:0] FLUSH_ASID = 2'b01;
  localparam logic [1:0] FLUSH_VPN = 2'b10;
  localparam logic [1:0] FLUSH_VPN_ASID = 2'b11;
  localparam logic [1:0] POL_FIFO = 2'b00;
  localparam logic [1:0] POL_LRU = 2'b01;
  localparam logic [1:0] POL_CLOCK = 2'b10;
  // Fields are sized to the widest supported configuration; narrower ports zero-extend.
  typedef struct packed {
    logic valid;
    logic [VPN_MAX-1:0] vpn;
    logic [ASID_MAX-1:0] asid;
    logic g;
    logic r;
    logic w;
    logic x;
    logic u;
    logic [PPN_MAX-1:0] ppn;
  } tlb_entry_t;
endpackage

// File: rtl/tlb_victim_select.sv
// tlb_victim_select: picks the refill slot (lowest free entry, else FIFO/LRU/Clock victim)
module tlb_victim_select
  import tlb_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IW = $clog2(ENTRIES)
) (
  input  logic [ENTRIES-1:0] valid,
  input  logic [IW-1:0]      age [ENTRIES],
  input  logic [ENTRIES-1:0] refb,
  input  logic [IW-1:0]      fifo_ptr,
  input  logic [IW-1:0]      hand,
  input  logic [1:0]         policy,
  output logic [IW-1:0]      slot,
  output logic               evict,
  output logic [IW-1:0]      hand_next,
  output logic [ENTRIES-1:0] ref_clr
);
  logic [IW-1:0] free_idx, lru_idx, clk_idx, idx;
  logic found, clock_pol;
  logic [ENTRIES-1:0] swept;
  always_comb begin
    free_idx = '0;
    evict = 1'b1;
    lru_idx = '0;
    clk_idx = hand;
    found = 1'b0;
    swept = refb;
    idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (!valid[i]) begin
        free_idx = IW'(i);
        evict = 1'b0;
      end
    for (int i = 1; i < ENTRIES; i++)
      if (age[i] > age[lru_idx]) lru_idx = IW'(i);
    // When every ref bit is set the sweep clears them all and the victim stays at the hand.
    for (int k = 0; k < ENTRIES; k++) begin
      idx = hand + IW'(k);
      if (!found) begin
        if (refb[idx]) swept[idx] = 1'b0;
        else begin
          found = 1'b1;
          clk_idx = idx;
        end
      end
    end
  end
  assign clock_pol = policy == POL_CLOCK;
  assign slot = !evict ? free_idx : policy == POL_LRU ? lru_idx : clock_pol ? clk_idx : fifo_ptr;
  assign hand_next = (evict & clock_pol) ? clk_idx + 1'b1 : hand;
  assign ref_clr = (evict & clock_pol) ? swept : refb;
endmodule

// File: rtl/tlb_assoc_asid.sv
// tlb_assoc_asid: fully-associative ASID-tagged TLB with targeted flush, permission check and selectable replacement
module tlb_assoc_asid
  import tlb_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int VPN_W = 20,
  parameter int PPN_W = 20,
  parameter int ASID_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lookup_valid,
  output logic              lookup_ready,
  input  logic [VPN_W-1:0]  lookup_vpn,
  input  logic [ASID_W-1:0] lookup_asid,
  input  logic              lookup_write,
  input  logic              lookup_user,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic              resp_fault,
  output logic [PPN_W-1:0]  resp_ppn,
  input  logic              refill_valid,
  input  logic [VPN_W-1:0]  refill_vpn,
  input  logic [ASID_W-1:0] refill_asid,
  input  logic [31:0]       refill_pte,
  input  logic              flush_valid,
  input  logic [1:0]        flush_mode,
  input  logic [ASID_W-1:0] flush_asid,
  input  logic [VPN_W-1:0]  flush_vpn,
  output logic              flush_done,
  input  logic [1:0]        replacement_policy,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
  output logic [31:0]       evict_count
);
  localparam int IW = $clog2(ENTRIES);
  tlb_entry_t ent [ENTRIES];
  tlb_entry_t lk_ent, rf_ent;
  logic [IW-1:0] age [ENTRIES];
  logic [IW-1:0] age_n [ENTRIES];
  logic [ENTRIES-1:0] refb, refb_n, ref_clr, kill, valid_f;
  logic [IW-1:0] fifo_ptr, hand, hand_next, lk_idx, rf_idx, sel_slot, slot, old_age;
  logic lk_fire, lk_hit, rf_fire, rf_hit, evict, repl, fault, unused_pte;
  assign lookup_ready = !flush_valid;
  assign lk_fire = lookup_valid & !flush_valid;
  assign rf_fire = refill_valid & refill_pte[PTE_V];
  assign unused_pte = ^refill_pte[PPN_LSB-1:PTE_G+1];
  assign rf_ent = '{valid: 1'b1, vpn: VPN_MAX'(refill_vpn), asid: ASID_MAX'(refill_asid),
                    g: refill_pte[PTE_G], r: refill_pte[PTE_R], w: refill_pte[PTE_W],
                    x: refill_pte[PTE_X], u: refill_pte[PTE_U], ppn: PPN_MAX'(refill_pte[31:PPN_LSB])};
  // Refill matching and slot choice use the post-flush valid vector so a same-cycle refill survives.
  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    rf_hit = 1'b0;
    rf_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      kill[i] = flush_valid & ent[i].valid & (flush_mode == FLUSH_ALL ? 1'b1 :
                flush_mode == FLUSH_VPN ? ent[i].vpn == VPN_MAX'(flush_vpn) :
                flush_mode == FLUSH_ASID ? !ent[i].g & ent[i].asid == ASID_MAX'(flush_asid) :
                !ent[i].g & ent[i].asid == ASID_MAX'(flush_asid) & ent[i].vpn == VPN_MAX'(flush_vpn));
      valid_f[i] = ent[i].valid & !kill[i];
      if (ent[i].valid && ent[i].vpn == VPN_MAX'(lookup_vpn) && (ent[i].g || ent[i].asid == ASID_MAX'(lookup_asid))) begin
        lk_hit = 1'b1;
        lk_idx = IW'(i);
      end
      if (valid_f[i] && ent[i].vpn == VPN_MAX'(refill_vpn) && (ent[i].g || ent[i].asid == ASID_MAX'(refill_asid))) begin
        rf_hit = 1'b1;
        rf_idx = IW'(i);
      end
    end
  end
  assign lk_ent = ent[lk_idx];
  assign fault = lk_hit & ((lookup_write & !lk_ent.w) | (!lookup_write & !lk_ent.r) | (lookup_user & !lk_ent.u));
  tlb_victim_select #(.ENTRIES(ENTRIES), .IW(IW)) u_victim (
    .valid(valid_f), .age(age), .refb(refb), .fifo_ptr(fifo_ptr), .hand(hand),
    .policy(replacement_policy), .slot(sel_slot), .evict(evict), .hand_next(hand_next), .ref_clr(ref_clr)
  );
  assign slot = rf_hit ? rf_idx : sel_slot;
  assign repl = rf_fire & !rf_hit & evict;
  // A freshly filled slot counts as the oldest, so every other entry ages past it.
  always_comb begin
    age_n = age;
    old_age = '0;
    if (lk_fire & lk_hit) begin
      for (int i = 0; i < ENTRIES; i++)
        if (age[i] < age[lk_idx]) age_n[i] = age[i] + 1'b1;
      age_n[lk_idx] = '0;
    end
    if (rf_fire) begin
      old_age = valid_f[slot] ? age_n[slot] : '1;
      for (int i = 0; i < ENTRIES; i++)
        if (age_n[i] < old_age) age_n[i] = age_n[i] + 1'b1;
      age_n[slot] = '0;
    end
    refb_n = repl ? ref_clr : refb;
    if (lk_fire & lk_hit) refb_n[lk_idx] = 1'b1;
    if (rf_fire) refb_n[slot] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ent <= '{default: '0};
      age <= '{default: '0};
      refb <= '0;
      fifo_ptr <= '0;
      hand <= '0;
      resp_valid <= 1'b0;
      resp_hit <= 1'b0;
      resp_fault <= 1'b0;
      resp_ppn <= '0;
      flush_done <= 1'b0;
      hit_count <= '0;
      miss_count <= '0;
      evict_count <= '0;
    end else begin
      resp_valid <= lk_fire;
      resp_hit <= lk_fire & lk_hit;
      resp_fault <= lk_fire & fault;
      resp_ppn <= (lk_fire & lk_hit & !fault) ? PPN_W'(lk_ent.ppn) : '0;
      flush_done <= flush_valid;
      for (int i = 0; i < ENTRIES; i++)
        if (kill[i]) ent[i].valid <= 1'b0;
      if (rf_fire) ent[slot] <= rf_ent;
      age <= age_n;
      refb <= refb_n;
      if (repl) begin
        fifo_ptr <= fifo_ptr + 1'b1;
        hand <= hand_next;
      end
      if (lk_fire & lk_hit & ~&hit_count) hit_count <= hit_count + 32'd1;
      if (lk_fire & !lk_hit & ~&miss_count) miss_count <= miss_count + 32'd1;
      if (repl & ~&evict_count) evict_count <= evict_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_tlb_assoc_asid.sv
// tb_tlb_assoc_asid: scoreboard bench with a behavioural TLB model, directed scenarios and randomized traffic
module tb_tlb_assoc_asid;
  localparam int N = 4;
  logic clk = 0, rst = 1;
  logic lookup_valid = 0, lookup_write = 0, lookup_user = 0;
  logic [19:0] lookup_vpn = 0, refill_vpn = 0, flush_vpn = 0;
  logic [7:0] lookup_asid = 0, refill_asid = 0, flush_asid = 0;
  logic refill_valid = 0, flush_valid = 0;
  logic [31:0] refill_pte = 0;
  logic [1:0] flush_mode = 0, policy = 0;
  logic lookup_ready, resp_valid, resp_hit, resp_fault, flush_done;
  logic [19:0] resp_ppn;
  logic [31:0] hit_count, miss_count, evict_count;
  always #5 clk = ~clk;

  tlb_assoc_asid #(.ENTRIES(N)) dut (
    .clk(clk), .rst(rst), .lookup_valid(lookup_valid), .lookup_ready(lookup_ready),
    .lookup_vpn(lookup_vpn), .lookup_asid(lookup_asid), .lookup_write(lookup_write), .lookup_user(lookup_user),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_fault(resp_fault), .resp_ppn(resp_ppn),
    .refill_valid(refill_valid), .refill_vpn(refill_vpn), .refill_asid(refill_asid), .refill_pte(refill_pte),
    .flush_valid(flush_valid), .flush_mode(flush_mode), .flush_asid(flush_asid), .flush_vpn(flush_vpn),
    .flush_done(flush_done), .replacement_policy(policy),
    .hit_count(hit_count), .miss_count(miss_count), .evict_count(evict_count)
  );

  typedef struct packed {logic hit; logic fault; logic [19:0] ppn;} resp_t;
  resp_t exp_q[$];
  resp_t got;
  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL resp_unexpected: got response %0h, expected none", {resp_hit, resp_fault, resp_ppn});
      end else begin
        got = exp_q.pop_front();
        chk("resp", 64'({resp_hit, resp_fault, resp_ppn}), 64'(got));
      end
    end

  // Reference model: a table of translations plus per-entry LRU age, clock ref bits, FIFO pointer, hand
  bit mv[N], mg[N], mr[N], mw[N], mu[N], mref[N];
  logic [19:0] mvpn[N], mppn[N];
  logic [7:0] masid[N];
  int mage[N];
  int mfifo, mhand;
  logic [31:0] mh, mm, me;

  function automatic bit m_match(int i, logic [19:0] v, logic [7:0] a);
    return mv[i] && mvpn[i] == v && (mg[i] || masid[i] == a);
  endfunction

  function automatic void touch(int t, int old);
    for (int j = 0; j < N; j++) if (mage[j] < old) mage[j]++;
    mage[t] = 0;
  endfunction

  task automatic model_edge();
    int li, s, old, best;
    bit f, kill, found;
    if (rst) begin
      for (int j = 0; j < N; j++) begin
        mv[j] = 0; mage[j] = 0; mref[j] = 0;
      end
      mfifo = 0; mhand = 0; mh = 0; mm = 0; me = 0;
      return;
    end
    if (lookup_valid && !flush_valid) begin
      li = -1;
      for (int j = 0; j < N; j++) if (li < 0 && m_match(j, lookup_vpn, lookup_asid)) li = j;
      if (li >= 0) begin
        f = (lookup_write && !mw[li]) || (!lookup_write && !mr[li]) || (lookup_user && !mu[li]);
        exp_q.push_back({1'b1, f, f ? 20'h0 : mppn[li]});
        if (mh != 32'hFFFFFFFF) mh++;
        touch(li, mage[li]);
        mref[li] = 1;
      end else begin
        exp_q.push_back(22'h0);
        if (mm != 32'hFFFFFFFF) mm++;
      end
    end
    if (flush_valid)
      for (int j = 0; j < N; j++) begin
        case (flush_mode)
          2'd0: kill = 1;
          2'd1: kill = !mg[j] && masid[j] == flush_asid;
          2'd2: kill = mvpn[j] == flush_vpn;
          default: kill = !mg[j] && masid[j] == flush_asid && mvpn[j] == flush_vpn;
        endcase
        if (kill) mv[j] = 0;
      end
    if (refill_valid && refill_pte[0]) begin
      s = -1;
      for (int j = 0; j < N; j++) if (s < 0 && m_match(j, refill_vpn, refill_asid)) s = j;
      if (s >= 0) old = mage[s];
      else begin
        for (int j = 0; j < N; j++) if (s < 0 && !mv[j]) s = j;
        if (s >= 0) old = N - 1;
        else begin
          if (policy == 2'd1) begin
            best = 0;
            for (int j = 1; j < N; j++) if (mage[j] > mage[best]) best = j;
            s = best;
          end else if (policy == 2'd2) begin
            found = 0;
            s = mhand;
            for (int k = 0; k < N; k++)
              if (!found) begin
                if (mref[(mhand + k) % N]) mref[(mhand + k) % N] = 0;
                else begin found = 1; s = (mhand + k) % N; end
              end
            mhand = (s + 1) % N;
          end else s = mfifo;
          mfifo = (mfifo + 1) % N;
          old = mage[s];
          if (me != 32'hFFFFFFFF) me++;
        end
      end
      touch(s, old);
      mref[s] = 1;
      mv[s] = 1; mvpn[s] = refill_vpn; masid[s] = refill_asid;
      mg[s] = refill_pte[5]; mr[s] = refill_pte[1]; mw[s] = refill_pte[2]; mu[s] = refill_pte[4];
      mppn[s] = refill_pte[31:12];
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    rst = 0; lookup_valid = 0; refill_valid = 0; flush_valid = 0;
  endtask

  task automatic set_lookup(input logic [19:0] v, input logic [7:0] a, input logic w, input logic u);
    lookup_valid = 1; lookup_vpn = v; lookup_asid = a; lookup_write = w; lookup_user = u;
  endtask
  task automatic set_refill(input logic [19:0] v, input logic [7:0] a, input logic [31:0] pte);
    refill_valid = 1; refill_vpn = v; refill_asid = a; refill_pte = pte;
  endtask
  task automatic set_flush(input logic [1:0] m, input logic [7:0] a, input logic [19:0] v);
    flush_valid = 1; flush_mode = m; flush_asid = a; flush_vpn = v;
  endtask
  task automatic lookup(input logic [19:0] v, input logic [7:0] a, input logic w, input logic u);
    set_lookup(v, a, w, u); step();
  endtask
  task automatic refill(input logic [19:0] v, input logic [7:0] a, input logic [31:0] pte);
    set_refill(v, a, pte); step();
  endtask
  task automatic restart(input logic [1:0] p);
    rst = 1; policy = p; step();
  endtask

  logic [19:0] ev_vpn;
  logic [31:0] pte;
  int op;
  initial begin
    restart(2'd0);
    chk("reset_resp_valid", 64'(resp_valid), 64'd0);
    chk("reset_ready", 64'(lookup_ready), 64'd1);
    chk("reset_flush_done", 64'(flush_done), 64'd0);
    chk("reset_counts", 64'({hit_count, miss_count} | 64'(evict_count)), 64'd0);
    lookup(20'h00001, 8'd3, 0, 0);
    chk("cold_miss_hit", 64'(resp_hit), 64'd0);
    chk("cold_miss_count", 64'(miss_count), 64'd1);
    refill(20'h00001, 8'd3, 32'h00001007);
    lookup(20'h00001, 8'd3, 0, 0);
    chk("refill_hit", 64'({resp_hit, resp_fault, resp_ppn}), 64'({2'b10, 20'h00001}));
    chk("refill_hit_count", 64'(hit_count), 64'd1);
    refill(20'h00002, 8'd3, 32'h00003007);
    lookup(20'h00002, 8'd4, 0, 0);
    chk("asid_isolation", 64'(resp_hit), 64'd0);
    refill(20'h00002, 8'd3, 32'h00005027);
    lookup(20'h00002, 8'd4, 0, 0);
    chk("global_hit", 64'({resp_hit, resp_ppn}), 64'({1'b1, 20'h00005}));
    refill(20'h00003, 8'd3, 32'h00007003);
    lookup(20'h00003, 8'd3, 1, 0);
    chk("store_fault", 64'({resp_hit, resp_fault, resp_ppn}), 64'({2'b11, 20'h0}));
    lookup(20'h00003, 8'd3, 0, 1);
    chk("user_fault", 64'(resp_fault), 64'd1);
    lookup(20'h00003, 8'd3, 0, 0);
    chk("load_ok", 64'({resp_fault, resp_ppn}), 64'({1'b0, 20'h00007}));
    set_flush(2'b01, 8'd3, 20'h0);
    set_lookup(20'h00001, 8'd3, 0, 0);
    #1;
    chk("flush_stalls_lookup", 64'(lookup_ready), 64'd0);
    step();
    chk("flush_done_pulse", 64'(flush_done), 64'd1);
    chk("flush_no_resp", 64'(resp_valid), 64'd0);
    lookup(20'h00002, 8'd3, 0, 0);
    chk("flush_asid_keeps_global", 64'(resp_hit), 64'd1);
    chk("flush_done_one_cycle", 64'(flush_done), 64'd0);
    lookup(20'h00001, 8'd3, 0, 0);
    chk("flush_asid_removed", 64'(resp_hit), 64'd0);
    set_flush(2'b00, 8'd0, 20'h0); step();
    lookup(20'h00002, 8'd4, 0, 0);
    chk("flush_all_empty", 64'(resp_hit), 64'd0);
    refill(20'h00030, 8'd1, 32'h00030007);
    set_flush(2'b00, 8'd0, 20'h0);
    set_refill(20'h00020, 8'd1, 32'h00020007);
    step();
    lookup(20'h00020, 8'd1, 0, 0);
    chk("flush_refill_survives", 64'(resp_hit), 64'd1);
    lookup(20'h00030, 8'd1, 0, 0);
    chk("flush_refill_old_gone", 64'(resp_hit), 64'd0);
    set_refill(20'h00021, 8'd1, 32'h00021007);
    set_lookup(20'h00021, 8'd1, 0, 0);
    step();
    chk("lookup_sees_pre_refill", 64'(resp_hit), 64'd0);
    set_lookup(20'h00020, 8'd1, 0, 0);
    rst = 1;
    step();
    chk("rst_drops_resp", 64'(resp_valid), 64'd0);
    chk("rst_clears_counts", 64'({hit_count, miss_count} | 64'(evict_count)), 64'd0);

    for (int p = 0; p < 3; p++) begin
      restart(2'(p));
      for (int i = 0; i < 4; i++) refill(20'h10 + 20'(i), 8'd1, {12'h0, 8'(8'h10 + 8'(i)), 12'h007});
      lookup(20'h10, 8'd1, 0, 0);
      refill(20'h14, 8'd1, 32'h00014007);
      chk("evict_count", 64'(evict_count), 64'd1);
      ev_vpn = (p == 1) ? 20'h11 : 20'h10;
      lookup(ev_vpn, 8'd1, 0, 0);
      chk("victim_evicted", 64'(resp_hit), 64'd0);
      lookup(20'h14, 8'd1, 0, 0);
      chk("new_entry_present", 64'({resp_hit, resp_ppn}), 64'({1'b1, 20'h14}));
    end

    for (int p = 0; p < 4; p++) begin
      restart(2'(p));
      repeat (200) begin
        op = $urandom_range(0, 9);
        if (op < 5)
          set_lookup(20'($urandom_range(0, 7)), 8'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        else if (op < 8) begin
          pte = $urandom;
          pte[0] = $urandom_range(0, 9) != 0;
          set_refill(20'($urandom_range(0, 7)), 8'($urandom_range(1, 3)), pte);
        end else if (op == 8)
          set_flush(2'($urandom_range(0, 3)), 8'($urandom_range(1, 3)), 20'($urandom_range(0, 7)));
        step();
      end
      step();
      chk("rand_hit_count", 64'(hit_count), 64'(mh));
      chk("rand_miss_count", 64'(miss_count), 64'(mm));
      chk("rand_evict_count", 64'(evict_count), 64'(me));
    end
    step();
    @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
